// File: rtl/async_fifo_rd_drain.sv
// Read-side drain controller for an async FIFO: credit-limited read issue,
// in-flight tracking, a small output buffer and a sticky protocol error flag.
module async_fifo_rd_drain #(
    parameter int WIDTH      = 32,
    parameter int BUF_DEPTH  = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic             rd_clk,
    input  logic             sync_rst,
    input  logic             drain_en,
    input  logic             empty,
    input  logic             rd_valid,
    input  logic [WIDTH-1:0] rd_data,
    output logic             rd_en,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [2:0]       in_flight,
    output logic [31:0]      word_count,
    output logic             err
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam int HW = $clog2(RD_LATENCY + 1);
    localparam int SW = ((CW > 3) ? CW : 3) + 1;

    logic [WIDTH-1:0] mem [BUF_DEPTH];
    logic [PW-1:0]    head, tail;
    logic [CW-1:0]    buf_count;
    logic [HW-1:0]    holdoff;
    logic [SW-1:0]    occupancy;
    logic             holdoff_active, full, pop, rv_live, rv_take, push, err_set;

    assign holdoff_active = (holdoff != '0);
    assign full           = (buf_count == CW'(BUF_DEPTH));
    assign out_valid      = (buf_count != '0);
    assign pop            = out_valid && out_ready;
    assign out_data       = out_valid ? mem[head] : '0;

    // Credit counts registered state only, so a pop frees space one cycle later.
    assign occupancy = SW'(in_flight) + SW'(buf_count);
    assign rd_en     = !sync_rst && drain_en && !empty && !holdoff_active
                       && (occupancy < SW'(BUF_DEPTH));

    // Returns during holdoff belong to reads killed by reset and are ignored.
    assign rv_live = rd_valid && !holdoff_active;
    assign rv_take = rv_live && (in_flight != '0);
    assign push    = rv_take && (!full || pop);
    assign err_set = rv_live && ((in_flight == '0) || (full && !pop));

    always_ff @(posedge rd_clk) begin
        if (sync_rst) begin
            head       <= '0;
            tail       <= '0;
            buf_count  <= '0;
            in_flight  <= '0;
            word_count <= '0;
            err        <= 1'b0;
            holdoff    <= HW'(RD_LATENCY);
        end else begin
            if (holdoff_active)
                holdoff <= holdoff - HW'(1);
            if (rd_en && !rv_take)
                in_flight <= in_flight + 3'd1;
            else if (!rd_en && rv_take)
                in_flight <= in_flight - 3'd1;
            if (push)
                tail <= tail + PW'(1);
            if (pop)
                head <= head + PW'(1);
            if (push && !pop)
                buf_count <= buf_count + CW'(1);
            else if (pop && !push)
                buf_count <= buf_count - CW'(1);
            if (pop)
                word_count <= word_count + 32'd1;
            if (err_set)
                err <= 1'b1;
        end
    end

    // Storage needs no reset; out_data is gated by out_valid.
    always_ff @(posedge rd_clk) begin
        if (!sync_rst && push)
            mem[tail] <= rd_data;
    end
endmodule

// File: tb/tb_async_fifo_rd_drain.sv
// Randomized bench for async_fifo_rd_drain: a queue-based FIFO model feeds the
// DUT and the delivered stream is compared with the words loaded into it.
module tb_async_fifo_rd_drain;
    localparam int W = 32;
    localparam int D = 4;
    localparam int L = 1;

    logic         clk = 1'b0;
    logic         sync_rst = 1'b1;
    logic         drain_en = 1'b0;
    logic         empty = 1'b1;
    logic         rd_valid = 1'b0;
    logic [W-1:0] rd_data = '0;
    logic         rd_en;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready = 1'b0;
    logic [2:0]   in_flight;
    logic [31:0]  word_count;
    logic         err;

    always #5 clk = ~clk;

    async_fifo_rd_drain #(.WIDTH(W), .BUF_DEPTH(D), .RD_LATENCY(L)) dut (
        .rd_clk(clk), .sync_rst(sync_rst), .drain_en(drain_en), .empty(empty),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_en(rd_en),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .in_flight(in_flight), .word_count(word_count), .err(err)
    );

    logic [W-1:0] src[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got[$];
    logic [W-1:0] pipe_d[L];
    bit           pipe_v[L];
    bit           inj = 0;
    logic [W-1:0] inj_d = '0;
    int cyc, n_en, en_cyc, rv_cyc, ov_cyc, hs_first, hs_last;
    logic [W-1:0] ov_data;
    int n_checks = 0;
    int n_fail = 0;

    // One clock cycle of the FIFO model; observations are taken mid-cycle.
    task automatic step();
        bit en_now;
        #1;
        en_now = rd_en;
        n_checks++;
        if (rd_en === 1'b1 && empty === 1'b1) begin
            n_fail++;
            $display("FAIL rd_en_while_empty: cyc=%0d rd_en=%b, required 0", cyc, rd_en);
        end
        if (en_now) begin n_en++; if (en_cyc < 0) en_cyc = cyc; end
        if (rd_valid && rv_cyc < 0) rv_cyc = cyc;
        if (out_valid && ov_cyc < 0) begin ov_cyc = cyc; ov_data = out_data; end
        if (out_valid && out_ready) begin
            got.push_back(out_data);
            if (hs_first < 0) hs_first = cyc;
            hs_last = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = L - 1; i > 0; i--) begin
            pipe_v[i] = pipe_v[i-1];
            pipe_d[i] = pipe_d[i-1];
        end
        pipe_v[0] = en_now;
        pipe_d[0] = (en_now && src.size() > 0) ? src.pop_front() : '0;
        rd_valid = pipe_v[L-1];
        rd_data  = pipe_d[L-1];
        if (inj) begin rd_valid = 1'b1; rd_data = inj_d; inj = 0; end
        empty = (src.size() == 0);
        #1;
    endtask

    task automatic clear_stats();
        cyc = 0; n_en = 0; en_cyc = -1; rv_cyc = -1; ov_cyc = -1;
        hs_first = -1; hs_last = -1; ov_data = '0;
        got.delete();
        exp_q.delete();
    endtask

    task automatic load_random(input int n);
        for (int i = 0; i < n; i++) begin
            logic [W-1:0] w;
            w = $urandom;
            src.push_back(w);
            exp_q.push_back(w);
        end
        empty = (src.size() == 0);
    endtask

    task automatic do_reset(input int n);
        sync_rst = 1'b1;
        src.delete();
        empty = 1'b1;
        rd_valid = 1'b0;
        for (int i = 0; i < L; i++) begin pipe_v[i] = 0; pipe_d[i] = '0; end
        repeat (n) step();
        sync_rst = 1'b0;
    endtask

    task automatic test_reset();
        sync_rst = 1'b1; drain_en = 1'b1; out_ready = 1'b1;
        src.delete(); src.push_back(32'h1); empty = 1'b0;
        repeat (3) step();
        n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b, required 0", rd_en); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h, required 0", out_data); end
        n_checks++; if (in_flight !== 3'd0) begin n_fail++; $display("FAIL reset_in_flight: got %0d, required 0", in_flight); end
        n_checks++; if (word_count !== 32'd0) begin n_fail++; $display("FAIL reset_word_count: got %0d, required 0", word_count); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, required 0", err); end
        n_checks++; if (dut.buf_count !== '0) begin n_fail++; $display("FAIL reset_buf_count: got %0d, required 0", dut.buf_count); end
        sync_rst = 1'b0;
        #1;
        n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL holdoff_rd_en: got %b, required 0", rd_en); end
        step();
        n_checks++; if (rd_en !== 1'b1) begin n_fail++; $display("FAIL after_holdoff_rd_en: got %b, required 1", rd_en); end
    endtask

    task automatic test_single_word();
        do_reset(5);
        clear_stats();
        drain_en = 1'b1; out_ready = 1'b1;
        src.push_back(32'h5); empty = 1'b0;
        repeat (8) step();
        n_checks++; if (n_en != 1) begin n_fail++; $display("FAIL single_rd_en_pulses: got %0d, required 1", n_en); end
        n_checks++; if (rv_cyc != en_cyc + 1) begin n_fail++; $display("FAIL single_rd_valid_cycle: got %0d, required %0d", rv_cyc, en_cyc + 1); end
        n_checks++; if (ov_cyc != en_cyc + 2) begin n_fail++; $display("FAIL single_out_valid_cycle: got %0d, required %0d", ov_cyc, en_cyc + 2); end
        n_checks++; if (ov_data !== 32'h5) begin n_fail++; $display("FAIL single_out_data: got %h, required 5", ov_data); end
        n_checks++; if (word_count !== 32'd1) begin n_fail++; $display("FAIL single_word_count: got %0d, required 1", word_count); end
        n_checks++; if (in_flight !== 3'd0) begin n_fail++; $display("FAIL single_in_flight: got %0d, required 0", in_flight); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b, required 0", err); end
    endtask

    task automatic test_streaming();
        do_reset(2);
        clear_stats();
        drain_en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            src.push_back(32'h10 + i);
            exp_q.push_back(32'h10 + i);
        end
        empty = 1'b0;
        for (int i = 0; i < 100 && got.size() < 16; i++) step();
        step();
        n_checks++; if (got.size() != 16) begin n_fail++; $display("FAIL stream_count: got %0d words, required 16", got.size()); end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL stream_order[%0d]: got %h, required %h", i, (i < got.size()) ? got[i] : '0, exp_q[i]);
            end
        end
        n_checks++; if (hs_first - en_cyc != 2) begin n_fail++; $display("FAIL stream_latency: got %0d, required 2", hs_first - en_cyc); end
        n_checks++; if (hs_last - hs_first != 15) begin n_fail++; $display("FAIL stream_back_to_back: span %0d, required 15", hs_last - hs_first); end
        n_checks++; if (word_count !== 32'd16) begin n_fail++; $display("FAIL stream_word_count: got %0d, required 16", word_count); end
    endtask

    task automatic test_backpressure();
        do_reset(2);
        clear_stats();
        drain_en = 1'b1; out_ready = 1'b0;
        load_random(10);
        repeat (10) step();
        n_checks++; if (n_en != D) begin n_fail++; $display("FAIL bp_reads_issued: got %0d, required %0d", n_en, D); end
        n_checks++; if (dut.buf_count !== D) begin n_fail++; $display("FAIL bp_buf_count: got %0d, required %0d", dut.buf_count, D); end
        n_checks++; if (in_flight !== 3'd0) begin n_fail++; $display("FAIL bp_in_flight: got %0d, required 0", in_flight); end
        n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL bp_rd_en: got %b, required 0", rd_en); end
        n_checks++; if (out_data !== exp_q[0]) begin n_fail++; $display("FAIL bp_head_stable: got %h, required %h", out_data, exp_q[0]); end
        out_ready = 1'b1;
        for (int i = 0; i < 100 && got.size() < 10; i++) step();
        n_checks++; if (got.size() != 10) begin n_fail++; $display("FAIL bp_drain_count: got %0d, required 10", got.size()); end
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL bp_order[%0d]: got %h, required %h", i, (i < got.size()) ? got[i] : '0, exp_q[i]);
            end
        end
    endtask

    task automatic test_errors();
        do_reset(2);
        clear_stats();
        drain_en = 1'b1; out_ready = 1'b1;
        step();
        inj = 1; inj_d = 32'hDEAD_BEEF;
        step();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_not_early: got %b, required 0", err); end
        step();
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b, required 1", err); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL err_no_push: got out_valid=%b, required 0", out_valid); end
        repeat (3) step();
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b, required 1", err); end
        n_checks++; if (word_count !== 32'd0) begin n_fail++; $display("FAIL err_word_count: got %0d, required 0", word_count); end
        do_reset(2);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_reset_clear: got %b, required 0", err); end
    endtask

    task automatic test_reset_mid_flight();
        do_reset(2);
        clear_stats();
        drain_en = 1'b1; out_ready = 1'b0;
        load_random(6);
        repeat (3) step();
        sync_rst = 1'b1;
        step();
        sync_rst = 1'b0;
        rd_valid = 1'b1; rd_data = 32'h0BAD_0BAD;
        #1;
        n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL mid_rst_holdoff_rd_en: got %b, required 0", rd_en); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_discard: got out_valid=%b, required 0", out_valid); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_err: got %b, required 0", err); end
        n_checks++; if (in_flight !== 3'd0) begin n_fail++; $display("FAIL mid_rst_in_flight: got %0d, required 0", in_flight); end
        n_checks++; if (rd_en !== 1'b1) begin n_fail++; $display("FAIL mid_rst_resume: got rd_en=%b, required 1", rd_en); end
    endtask

    task automatic test_wrap_drain_en();
        int n_off;
        do_reset(2);
        clear_stats();
        drain_en = 1'b1;
        load_random(37);
        for (int i = 0; i < 400 && got.size() < 37; i++) begin
            out_ready = (i % 2 == 0);
            step();
        end
        out_ready = 1'b0;
        step();
        n_checks++; if (got.size() != 37) begin n_fail++; $display("FAIL wrap_count: got %0d, required 37", got.size()); end
        for (int i = 0; i < 37; i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL wrap_order[%0d]: got %h, required %h", i, (i < got.size()) ? got[i] : '0, exp_q[i]);
            end
        end
        n_checks++; if (word_count !== 32'd37) begin n_fail++; $display("FAIL wrap_word_count: got %0d, required 37", word_count); end

        do_reset(2);
        clear_stats();
        drain_en = 1'b1; out_ready = 1'b1;
        load_random(20);
        for (int i = 0; i < 20 && n_en < 3; i++) step();
        drain_en = 1'b0;
        #1;
        n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL drain_off_same_cycle: got rd_en=%b, required 0", rd_en); end
        n_off = n_en;
        repeat (6) step();
        n_checks++; if (n_en != n_off) begin n_fail++; $display("FAIL drain_off_no_reads: got %0d reads, required %0d", n_en, n_off); end
        n_checks++; if (got.size() != n_off) begin n_fail++; $display("FAIL drain_off_delivered: got %0d words, required %0d", got.size(), n_off); end
        for (int i = 0; i < n_off; i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL drain_off_order[%0d]: got %h, required %h", i, (i < got.size()) ? got[i] : '0, exp_q[i]);
            end
        end
        n_checks++; if (in_flight !== 3'd0) begin n_fail++; $display("FAIL drain_off_in_flight: got %0d, required 0", in_flight); end
    endtask

    task automatic test_random();
        do_reset(2);
        clear_stats();
        load_random(60);
        for (int i = 0; i < 2000 && got.size() < 60; i++) begin
            drain_en  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            step();
        end
        out_ready = 1'b0;
        step();
        n_checks++; if (got.size() != 60) begin n_fail++; $display("FAIL rand_count: got %0d, required 60", got.size()); end
        for (int i = 0; i < 60; i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand_order[%0d]: got %h, required %h", i, (i < got.size()) ? got[i] : '0, exp_q[i]);
            end
        end
        n_checks++; if (word_count !== 32'd60) begin n_fail++; $display("FAIL rand_word_count: got %0d, required 60", word_count); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rand_err: got %b, required 0", err); end
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_single_word();
        test_streaming();
        test_backpressure();
        test_errors();
        test_reset_mid_flight();
        test_wrap_drain_en();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/async_fifo_rd_drain.md
# async_fifo_rd_drain

Read-side drain controller that sits directly downstream of the async FIFO in the read clock domain. It issues `rd_en` only when the FIFO is non-empty and buffer credit exists, tracks reads in flight against the FIFO's `rd_valid` return, and captures returned words in a small local buffer. It presents them as a valid/ready stream to the consumer and flags protocol violations.

## Interface
- `WIDTH`, 32: data width; matches the FIFO `rd_data` width.
- `BUF_DEPTH`, 4: local output buffer entries; must be a power of 2, ≥ `RD_LATENCY`+2.
- `RD_LATENCY`, 1: rd_en-to-rd_valid latency in rd_clk cycles, 1..4.
- `rd_clk  in  1`: read-domain clock, rising-edge.
- `sync_rst  in  1`: synchronous, active-high reset.
- `drain_en  in  1`: permits issuing new reads; in-flight reads always complete.
- `empty  in  1`: FIFO empty flag, rd_clk domain.
- `rd_valid  in  1`: FIFO read-data-valid strobe.
- `rd_data  in  WIDTH`: FIFO read data, qualified by `rd_valid`.
- `rd_en  out  1`: FIFO read request, combinational.
- `out_valid  out  1`: head of local buffer is valid.
- `out_data  out  WIDTH`: head word.
- `out_ready  in  1`: consumer accepts head when high with `out_valid`.
- `in_flight  out  3`: reads issued whose `rd_valid` has not returned.
- `word_count  out  32`: count of words accepted on the output, wraps at 2^32.
- `err  out  1`: sticky protocol error, cleared only by reset.

## Operation
- `rd_en = !sync_rst && drain_en && !empty && (in_flight + buf_count < BUF_DEPTH)`. It never asserts while `empty` is high.
- Credit is conservative: an output pop in the same cycle does not free credit until the next cycle.
- `in_flight` behaviour per edge:
  - +1 on `rd_en`.
  - −1 on an accepted `rd_valid`.
  - Unchanged when both occur in the same cycle.
- Local buffer is a circular FIFO of `BUF_DEPTH` entries with head/tail pointers and `buf_count` (0..`BUF_DEPTH`).
- Push on `rd_valid`; pop on `out_valid && out_ready`. Simultaneous push and pop leaves `buf_count` unchanged. Pointers wrap mod `BUF_DEPTH`.
- There is no bypass: a word pushed at edge t is visible on `out_data` only after edge t, even when the buffer was empty.
- `out_valid = (buf_count != 0)`. `out_data` is the head entry and holds stable while `out_valid && !out_ready`.
- `word_count` increments on every output handshake.
- Error conditions, each setting `err` at the next edge:
  - `rd_valid` while `in_flight == 0`: word dropped, no push.
  - `rd_valid` while `buf_count == BUF_DEPTH` with no simultaneous pop: word dropped.
  - `empty` high in a cycle where `rd_valid` is expected is not an error.
- Post-reset holdoff: a counter loaded with `RD_LATENCY` on reset decrements each cycle after `sync_rst` falls.
  - While nonzero, `rd_valid` is silently discarded with no error and no push, so returns from reads killed by reset are absorbed.
  - `rd_en` is held low during holdoff.

## Timing
- Reset values: `rd_en`=0, `out_valid`=0, `out_data`=0, `in_flight`=0, `word_count`=0, `err`=0, `buf_count`=0, pointers=0, holdoff=`RD_LATENCY`.
- Reset mid-operation: buffer contents and in-flight reads are abandoned, and all state returns to reset values at that edge.
- Latency with `RD_LATENCY`=1: `rd_en` high in cycle t, `rd_valid` high in cycle t+1, push at the end of t+1, `out_valid` high in cycle t+2.
- Sustained throughput is 1 word/cycle when `out_ready` is held high and the FIFO stays non-empty.
- `drain_en` deassertion takes effect combinationally on `rd_en` in the same cycle.

## Test plan
- **Single word:** reset 5 cycles, FIFO holds 0x5, `out_ready`=1, `drain_en`=1.
  - Expect exactly one `rd_en` pulse and `rd_valid` one cycle later.
  - `out_valid` with `out_data`=0x5 one cycle after that.
  - Then `word_count`=1, `in_flight`=0, `err`=0.
- **Streaming:** FIFO preloaded with 0x10..0x1F, `out_ready`=1.
  - Expect 16 words out in order on consecutive cycles after the initial 2-cycle latency, and `word_count`=16.
  - No `rd_en` while `empty`=1.
- **Backpressure:** `out_ready`=0, 10 words available.
  - Expect exactly 4 reads issued, `buf_count`=4, `in_flight`=0, `rd_en` held low, and `out_data` stable at the first word.
  - Raise `out_ready`: all 10 words drain in order.
- **Errors:**
  - Force `rd_valid`=1 with `in_flight`=0: `err`=1 next cycle, no output word, `err` stays high.
  - A subsequent reset clears `err`.
- **Reset mid-flight:** assert `sync_rst` in the cycle `rd_en` is high, deassert next cycle, then `rd_valid` pulses.
  - Expect the word discarded, `err`=0, `out_valid`=0, and `rd_en` low for 1 cycle after reset.
- **Wrap and drain_en:**
  - 37 words with `out_ready` toggling 1-0-1-0: all 37 emerge in order, covering pointer wrap.
  - Drop `drain_en` mid-stream: `rd_en` low the same cycle, and the in-flight word still delivered.
